// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N_REQ-way memory arbiter with round-robin or fixed priority selection,
// a bounded grant tenure while others wait, and a one-shot exclusion of a preempted owner.
// All state updates on the falling edge of clk.
//
// Ports:
//   clk      - clock; state updates on the falling edge
//   reset    - synchronous active-high reset, sampled on the falling edge
//   req      - level request per requester, held for the whole access
//   grant    - registered one-hot (or zero) grant
//   grant_id - index of the current owner, 0 when idle
//   busy     - high while any grant bit is high
//   preempt  - one-cycle pulse after a forced release by timeout
module mem_arbiter_rr #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned MAX_HOLD  = 16,
  localparam int unsigned IdW      = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IdW-1:0]   grant_id,
  output logic             busy,
  output logic             preempt
);

  typedef enum logic {StIdle, StOwned} state_e;

  localparam logic [IdW:0] NReqW   = (IdW + 1)'(N_REQ);
  // Hold count at which a waiting requester forces a release
  localparam logic [7:0]   HoldLim = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  // Declaration initialisers match the reset values so outputs are defined before reset
  state_e           r_state     = StIdle;
  logic [N_REQ-1:0] r_grant     = '0;
  logic [IdW-1:0]   r_grant_id  = '0;
  logic [7:0]       r_hold      = '0;
  logic [IdW-1:0]   r_rr_ptr    = '0;
  logic             r_preempt   = 1'b0;
  logic             r_excl_vld  = 1'b0;
  logic [IdW-1:0]   r_excl_idx  = '0;

  state_e           w_state_d;
  logic [N_REQ-1:0] w_grant_d;
  logic [IdW-1:0]   w_grant_id_d;
  logic [7:0]       w_hold_d;
  logic [IdW-1:0]   w_rr_ptr_d;
  logic             w_preempt_d;
  logic             w_excl_vld_d;
  logic [IdW-1:0]   w_excl_idx_d;

  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_rot;
  logic [N_REQ-1:0] w_onehot;
  logic [IdW-1:0]   w_base;
  logic [IdW-1:0]   w_off;
  logic [IdW:0]     w_sum;
  logic [IdW:0]     w_inc;
  logic [IdW-1:0]   w_win;
  logic [IdW-1:0]   w_ptr_nxt;
  logic             w_found;
  logic             w_owner_req;
  logic             w_other;
  logic             w_timeout;

  // Winner selection: rotate the eligible vector so the search base sits at bit 0,
  // take the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    w_elig = req;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (r_excl_vld && (r_excl_idx == IdW'(i))) w_elig[i] = 1'b0;
    end
    w_base  = (PRIO_MODE == 1) ? '0 : r_rr_ptr;
    w_rot   = N_REQ'({w_elig, w_elig} >> w_base);
    w_found = 1'b0;
    w_off   = '0;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IdW'(i);
      end
    end
    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= NReqW) w_sum = w_sum - NReqW;
    w_win = w_sum[IdW-1:0];
    w_inc = {1'b0, w_win} + (IdW + 1)'(1);
    if (w_inc == NReqW) w_inc = '0;
    w_ptr_nxt = w_inc[IdW-1:0];
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_onehot[i] = (w_win == IdW'(i));
    end
  end

  // r_grant is one-hot on the owner while OWNED, so it doubles as the owner mask
  assign w_owner_req = |(req & r_grant);
  assign w_other     = |(req & ~r_grant);
  assign w_timeout   = (MAX_HOLD != 0) && w_other && (r_hold >= HoldLim);

  always_comb begin
    w_state_d    = r_state;
    w_grant_d    = r_grant;
    w_grant_id_d = r_grant_id;
    w_hold_d     = r_hold;
    w_rr_ptr_d   = r_rr_ptr;
    w_preempt_d  = 1'b0;
    w_excl_vld_d = r_excl_vld;
    w_excl_idx_d = r_excl_idx;
    unique case (r_state)
      StIdle: begin
        // Exclusion applies to a single IDLE arbitration, granted or not
        w_excl_vld_d = 1'b0;
        if (w_found) begin
          w_grant_d    = w_onehot;
          w_grant_id_d = w_win;
          w_hold_d     = '0;
          w_rr_ptr_d   = w_ptr_nxt;
          w_state_d    = StOwned;
        end
      end
      StOwned: begin
        if (!w_owner_req) begin
          w_grant_d    = '0;
          w_grant_id_d = '0;
          w_hold_d     = '0;
          w_state_d    = StIdle;
        end else if (w_timeout) begin
          w_grant_d    = '0;
          w_grant_id_d = '0;
          w_hold_d     = '0;
          w_preempt_d  = 1'b1;
          w_excl_vld_d = 1'b1;
          w_excl_idx_d = r_grant_id;
          w_state_d    = StIdle;
        end else if (w_other && (r_hold != 8'hFF)) begin
          w_hold_d = r_hold + 8'd1;
        end
      end
      default: begin
        w_grant_d    = '0;
        w_grant_id_d = '0;
        w_state_d    = StIdle;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_hold     <= '0;
      r_rr_ptr   <= '0;
      r_preempt  <= 1'b0;
      r_excl_vld <= 1'b0;
      r_excl_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_grant_id <= w_grant_id_d;
      r_hold     <= w_hold_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_preempt  <= w_preempt_d;
      r_excl_vld <= w_excl_vld_d;
      r_excl_idx <= w_excl_idx_d;
    end
  end

  assign grant    = r_grant;
  assign grant_id = r_grant_id;
  assign busy     = |r_grant;
  assign preempt  = r_preempt;

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 Parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-003 Parameter MAX_HOLD, default 16: maximum grant tenure in cycles while another requester waits; 0 = unlimited; legal range 0..255.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on the falling edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset, sampled on the falling edge of clk.
REQ-006 Port req, input, N_REQ bits: level request, one bit per requester; held high for the whole access.
REQ-007 Port grant, output, N_REQ bits: registered grant, one-hot or all-zero.
REQ-008 Port grant_id, output, clog2(N_REQ) bits: index of the current owner; 0 when no grant is active.
REQ-009 Port busy, output, 1 bit: high while any grant bit is high.
REQ-010 Port preempt, output, 1 bit: single-cycle pulse marking a forced release by timeout.

Function
REQ-011 States SHALL be IDLE and OWNED; OWNED records the owner index and a hold counter of 8 bits.
REQ-012 IDLE with req != 0: at the next edge, set grant[winner]=1, load grant_id, clear the hold counter, and move to OWNED.
REQ-013 IDLE with req == 0: outputs SHALL stay all-zero and the state SHALL remain IDLE.
REQ-014 Grant latency SHALL be 1 edge from the edge at which req is sampled high in IDLE.
REQ-015 Winner selection in fixed mode (PRIO_MODE=1): lowest set index of req.
REQ-016 Winner selection in round-robin mode (PRIO_MODE=0): first set bit of req at or above rr_ptr, wrapping from N_REQ-1 to 0.
REQ-017 rr_ptr SHALL be set to (winner+1) mod N_REQ on every grant; reset value is 0.
REQ-018 OWNED with req[owner]=1: the grant SHALL be held unchanged; requests from other indices SHALL be ignored for grant purposes.
REQ-019 OWNED with req[owner]=0 at an edge: clear grant, set grant_id=0, and return to IDLE.
REQ-020 A normal release SHALL cost exactly one IDLE cycle: a new grant appears no earlier than the second edge after the owner drops req.
REQ-021 The hold counter SHALL increment each OWNED edge while any other req bit is set, saturating at 255; it SHALL stay unchanged while no other requester waits.
REQ-022 Timeout: if MAX_HOLD>0 and the hold counter reaches MAX_HOLD-1 with another requester waiting, the next edge SHALL clear grant, pulse preempt for one cycle, and go to IDLE, even though req[owner] is still 1.
REQ-023 After a preemption, the preempted index SHALL be excluded from selection at the next IDLE arbitration only; in fixed mode this means the next-lowest requester wins.
REQ-024 grant SHALL never have more than one bit set, and grant SHALL never be set for an index whose req was 0 at the granting edge.
REQ-025 req changes during the IDLE cycle SHALL be resolved using the value sampled at the granting edge.
REQ-026 grant_id width SHALL be max(1, clog2(N_REQ)).

Reset
REQ-027 On reset at an edge, the block SHALL force IDLE; grant=0, grant_id=0, busy=0, preempt=0, rr_ptr=0, hold counter=0, and clear the exclusion flag.
REQ-028 Reset asserted mid-grant SHALL drop grant at that same edge; the first new grant SHALL come no earlier than the first edge after reset deasserts.
REQ-029 The initial register values SHALL equal the reset values, so that outputs are defined before the first reset.

Verification (N_REQ=4, MAX_HOLD=4 unless noted)
REQ-030 PRIO_MODE=1, req=4'b0110 from IDLE -> grant=4'b0010 and grant_id=1 one edge later; hold req -> grant stable.
REQ-031 PRIO_MODE=0, req=4'b1111 held, each owner drops req for one cycle after access -> grant sequence 0001, 0010, 0100, 1000, 0001, with one all-zero cycle between grants.
REQ-032 req=4'b0001 alone held 20 cycles -> grant=0001 throughout, preempt never pulses (no other waiter).
REQ-033 req=4'b0011 held, PRIO_MODE=1 -> owner 0 preempted after 4 OWNED edges: preempt=1 for one cycle, then grant=0010 after the IDLE cycle.
REQ-034 Reset pulsed while grant=0100 -> grant=0 at that edge, rr_ptr=0; after deassertion with req=4'b1100 and PRIO_MODE=0 -> grant=0100.
REQ-035 Randomised req over 10k cycles for both modes -> assertions hold for REQ-024, for busy == |grant, and for the 1-cycle minimum gap between grants.
